// File: rtl/turtle_dmem_arbiter_if.sv
// turtle_dmem_arbiter_if: requester-side bus of the data-memory arbiter.
// Rev 1.0 - initial release.
`default_nettype none

interface turtle_dmem_arbiter_if #(
  parameter int DATA_W   = 8,
  parameter int D_ADDR_W = 12,
  parameter int NUM_CH   = 2
);
  logic [NUM_CH-1:0]          req;
  logic [NUM_CH-1:0]          we;
  logic [NUM_CH-1:0]          lock;
  logic [NUM_CH*D_ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0]   wdata;
  logic [NUM_CH-1:0]          gnt;
  logic [NUM_CH-1:0]          rvalid;
  logic [DATA_W-1:0]          rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

`default_nettype wire

// File: rtl/turtle_dmem_arbiter.sv
// turtle_dmem_arbiter: N-channel round-robin / fixed-priority arbiter with locked
// multi-beat sequences onto the single data_memory port. Rev 1.0 - initial release.
`default_nettype none

module turtle_dmem_arbiter #(
  parameter int DATA_W     = 8,
  parameter int D_ADDR_W   = 12,
  parameter int NUM_CH     = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset,
  turtle_dmem_arbiter_if.slave bus,
  output logic [D_ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0]   write_data,
  output logic                write_enable,
  output logic                output_enable,
  input  logic [DATA_W-1:0]   read_data
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_nx;
  logic [PTR_W-1:0]  owner, owner_nx;
  logic [PTR_W-1:0]  g;
  logic              granted;
  logic              hold;
  logic [NUM_CH-1:0] rvalid_q, rvalid_nx;
  logic [DATA_W-1:0] rdata_q, rdata_nx;
  int                idx;

  // The owner keeps the port only while it still requests; dropping req releases it at once.
  always_comb begin
    granted = 1'b0;
    g       = '0;
    idx     = 0;
    hold    = (state == LOCKED) && bus.req[owner];
    if (!reset) begin
      if (hold) begin
        granted = 1'b1;
        g       = owner;
      end else if (FIXED_PRIO != 0) begin
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (bus.req[i]) begin
            granted = 1'b1;
            g       = PTR_W'(i);
          end
        end
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          idx = int'(rr_ptr) + k;
          if (idx >= NUM_CH) idx = idx - NUM_CH;
          if (!granted && bus.req[idx]) begin
            granted = 1'b1;
            g       = PTR_W'(idx);
          end
        end
      end
    end
  end

  assign bus.gnt       = granted ? (NUM_CH'(1) << g) : '0;
  assign data_addr     = granted ? bus.addr[g*D_ADDR_W +: D_ADDR_W] : '0;
  assign write_data    = granted ? bus.wdata[g*DATA_W +: DATA_W] : '0;
  assign write_enable  = granted &  bus.we[g];
  assign output_enable = granted & ~bus.we[g];
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;

  always_comb begin
    state_nx  = IDLE;
    owner_nx  = owner;
    rr_ptr_nx = rr_ptr;
    rvalid_nx = '0;
    rdata_nx  = rdata_q;
    if (granted) begin
      owner_nx = g;
      state_nx = bus.lock[g] ? LOCKED : IDLE;
      if (FIXED_PRIO == 0 && !bus.lock[g])
        rr_ptr_nx = (g == PTR_W'(NUM_CH - 1)) ? '0 : g + 1'b1;
      if (!bus.we[g]) begin
        rvalid_nx = NUM_CH'(1) << g;
        rdata_nx  = read_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      owner    <= owner_nx;
      rvalid_q <= rvalid_nx;
      rdata_q  <= rdata_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_turtle_dmem_arbiter.sv
// tb_turtle_dmem_arbiter: directed self-checking bench for turtle_dmem_arbiter.
// Rev 1.0 - initial release.
`default_nettype none

module tb_turtle_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  turtle_dmem_arbiter_if #(.NUM_CH(2)) b2 ();
  turtle_dmem_arbiter_if #(.NUM_CH(3)) b3 ();
  turtle_dmem_arbiter_if #(.NUM_CH(3)) b3f ();

  logic [11:0] a2, a3, a3f;
  logic [7:0]  wd2, wd3, wd3f, rd2, rd3, rd3f;
  logic        we2, we3, we3f, oe2, oe3, oe3f;
  logic [7:0]  mem [0:4095];

  turtle_dmem_arbiter #(.NUM_CH(2), .FIXED_PRIO(0)) dut2 (
    .clk(clk), .reset(reset), .bus(b2), .data_addr(a2), .write_data(wd2),
    .write_enable(we2), .output_enable(oe2), .read_data(rd2));
  turtle_dmem_arbiter #(.NUM_CH(3), .FIXED_PRIO(0)) dut3 (
    .clk(clk), .reset(reset), .bus(b3), .data_addr(a3), .write_data(wd3),
    .write_enable(we3), .output_enable(oe3), .read_data(rd3));
  turtle_dmem_arbiter #(.NUM_CH(3), .FIXED_PRIO(1)) dut3f (
    .clk(clk), .reset(reset), .bus(b3f), .data_addr(a3f), .write_data(wd3f),
    .write_enable(we3f), .output_enable(oe3f), .read_data(rd3f));

  assign rd2  = mem[a2];
  assign rd3  = a3[7:0];
  assign rd3f = a3f[7:0];

  always @(posedge clk) if (we2) mem[a2] <= wd2;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    b2.req = '0;  b2.we = '0;  b2.lock = '0;  b2.addr = '0;  b2.wdata = '0;
    b3.req = '0;  b3.we = '0;  b3.lock = '0;  b3.addr = '0;  b3.wdata = '0;
    b3f.req = '0; b3f.we = '0; b3f.lock = '0; b3f.addr = '0; b3f.wdata = '0;
  endtask

  task automatic test_reset;
    idle_all();
    reset = 1'b1;
    b2.req = 2'b11; b3.req = 3'b111; b3f.req = 3'b111;
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (b2.gnt !== 2'b00 || b3.gnt !== 3'b000 || b3f.gnt !== 3'b000)
        $display("FAIL reset_gnt: got %b/%b/%b required 0", b2.gnt, b3.gnt, b3f.gnt);
      else passed++;
      checks++;
      if (we2 !== 1'b0 || oe2 !== 1'b0 || a2 !== 12'h000)
        $display("FAIL reset_mem: got we=%b oe=%b addr=%h required 0", we2, oe2, a2);
      else passed++;
      tick();
      checks++;
      if (b2.rvalid !== 2'b00 || b2.rdata !== 8'h00 || b3.rvalid !== 3'b000)
        $display("FAIL reset_regs: got rvalid=%b rdata=%h required 0", b2.rvalid, b2.rdata);
      else passed++;
    end
    reset = 1'b0;
    idle_all();
    tick();
  endtask

  task automatic test_write_read;
    b2.req = 2'b10; b2.we = 2'b10; b2.addr = {12'h123, 12'h000}; b2.wdata = {8'hA5, 8'h00};
    #1;
    checks++;
    if (b2.gnt !== 2'b10 || we2 !== 1'b1 || oe2 !== 1'b0 || a2 !== 12'h123 || wd2 !== 8'hA5)
      $display("FAIL wr_beat: got gnt=%b we=%b oe=%b addr=%h wd=%h required 10/1/0/123/a5",
               b2.gnt, we2, oe2, a2, wd2);
    else passed++;
    tick();
    b2.we = 2'b00;
    #1;
    checks++;
    if (b2.gnt !== 2'b10 || oe2 !== 1'b1 || we2 !== 1'b0 || b2.rvalid !== 2'b00)
      $display("FAIL rd_beat: got gnt=%b oe=%b we=%b rvalid=%b required 10/1/0/00",
               b2.gnt, oe2, we2, b2.rvalid);
    else passed++;
    tick();
    b2.req = 2'b00;
    #1;
    checks++;
    if (b2.rvalid !== 2'b10 || b2.rdata !== 8'hA5)
      $display("FAIL rd_return: got rvalid=%b rdata=%h required 10/a5", b2.rvalid, b2.rdata);
    else passed++;
    checks++;
    if (b2.gnt !== 2'b00 || a2 !== 12'h000 || oe2 !== 1'b0)
      $display("FAIL no_grant: got gnt=%b addr=%h oe=%b required 0", b2.gnt, a2, oe2);
    else passed++;
    tick();
    checks++;
    if (b2.rvalid !== 2'b00 || b2.rdata !== 8'hA5)
      $display("FAIL rdata_hold: got rvalid=%b rdata=%h required 00/a5", b2.rvalid, b2.rdata);
    else passed++;
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_g, prev_g;
    prev_g = 3'b000;
    b3.req = 3'b111; b3f.req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp_g = 3'b001 << (c % 3);
      #1;
      checks++;
      if (b3.gnt !== exp_g)
        $display("FAIL rr_order[%0d]: got %b required %b", c, b3.gnt, exp_g);
      else passed++;
      checks++;
      if (b3f.gnt !== 3'b001)
        $display("FAIL fixed_prio[%0d]: got %b required 001", c, b3f.gnt);
      else passed++;
      if (c > 0) begin
        checks++;
        if (b3.rvalid !== prev_g)
          $display("FAIL rr_rvalid[%0d]: got %b required %b", c, b3.rvalid, prev_g);
        else passed++;
      end
      prev_g = exp_g;
      tick();
    end
    b3.req = '0; b3f.req = '0;
    tick();
  endtask

  task automatic test_lock_rmw;
    b2.req = 2'b10; b2.we = 2'b00; b2.lock = 2'b10; b2.addr = {12'h010, 12'h000};
    #1;
    checks++;
    if (b2.gnt !== 2'b10) $display("FAIL lock_first: got %b required 10", b2.gnt);
    else passed++;
    tick();
    b2.req = 2'b11; b2.we = 2'b10; b2.lock = 2'b00;
    b2.addr = {12'h010, 12'h050}; b2.wdata = {8'h5A, 8'h00};
    #1;
    checks++;
    if (b2.gnt !== 2'b10 || we2 !== 1'b1 || a2 !== 12'h010)
      $display("FAIL lock_hold: got gnt=%b we=%b addr=%h required 10/1/010", b2.gnt, we2, a2);
    else passed++;
    checks++;
    if (b2.rvalid !== 2'b10 || b2.rdata !== 8'h3C)
      $display("FAIL lock_read: got rvalid=%b rdata=%h required 10/3c", b2.rvalid, b2.rdata);
    else passed++;
    tick();
    b2.we = 2'b00; b2.addr = {12'h010, 12'h010};
    #1;
    checks++;
    if (b2.gnt !== 2'b01 || a2 !== 12'h010)
      $display("FAIL lock_after: got gnt=%b addr=%h required 01/010", b2.gnt, a2);
    else passed++;
    tick();
    b2.req = 2'b00;
    #1;
    checks++;
    if (b2.rvalid !== 2'b01 || b2.rdata !== 8'h5A)
      $display("FAIL rmw_result: got rvalid=%b rdata=%h required 01/5a", b2.rvalid, b2.rdata);
    else passed++;
    tick();
  endtask

  task automatic test_lock_drop;
    b2.req = 2'b01; b2.we = 2'b00; b2.lock = 2'b01; b2.addr = {12'h000, 12'h020};
    #1;
    checks++;
    if (b2.gnt !== 2'b01) $display("FAIL drop_lock: got %b required 01", b2.gnt);
    else passed++;
    tick();
    b2.req = 2'b10; b2.lock = 2'b00; b2.addr = {12'h030, 12'h020};
    #1;
    checks++;
    if (b2.gnt !== 2'b10 || a2 !== 12'h030)
      $display("FAIL drop_release: got gnt=%b addr=%h required 10/030", b2.gnt, a2);
    else passed++;
    tick();
    b2.req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_lock;
    b2.req = 2'b01; b2.we = 2'b00; b2.lock = 2'b01; b2.addr = {12'h000, 12'h0FF};
    #1;
    checks++;
    if (b2.gnt !== 2'b01) $display("FAIL midlock_gnt: got %b required 01", b2.gnt);
    else passed++;
    tick();
    reset = 1'b1; b2.req = 2'b11;
    #1;
    checks++;
    if (b2.gnt !== 2'b00 || we2 !== 1'b0 || oe2 !== 1'b0 || a2 !== 12'h000)
      $display("FAIL midlock_reset: got gnt=%b we=%b oe=%b addr=%h required 0",
               b2.gnt, we2, oe2, a2);
    else passed++;
    checks++;
    if (b2.rvalid !== 2'b01)
      $display("FAIL midlock_inflight: got %b required 01", b2.rvalid);
    else passed++;
    tick();
    reset = 1'b0; b2.req = 2'b10; b2.lock = 2'b00; b2.addr = {12'h040, 12'h0FF};
    #1;
    checks++;
    if (b2.rvalid !== 2'b00 || b2.gnt !== 2'b10)
      $display("FAIL midlock_after: got rvalid=%b gnt=%b required 00/10", b2.rvalid, b2.gnt);
    else passed++;
    tick();
    b2.req = 2'b00;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h010] = 8'h3C;
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock_rmw();
    test_lock_drop();
    test_reset_mid_lock();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
